aggr_serializer: RTL and testbench

Consumer for the aggregation unit's result interface. Captures each wide `aggr_pack` word on `aggr_valid` into a two-entry buffer, then streams it out one channel per beat over a valid/ready handshake. Each channel passes through optional ReLU, an arithmetic right shift and signed saturation on the way out. Sits between the aggregation stage and the next layer's input FIFO, and is the only place a node's feature vector is narrowed to activation width.

---
 rtl/aggr_serializer.sv | 148 ++++++++++++++
 tb/tb_aggr_serializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aggr_serializer.sv
// aggr_serializer: buffers wide aggregation result words in a two-entry FIFO
// and streams them out one quantized channel per beat over valid/ready.
module aggr_serializer #(
    parameter int OUT_C   = 32,
    parameter int B_WIDTH = 32,
    parameter int Q_WIDTH = 8,
    parameter int SHIFT   = 8,
    parameter int RELU    = 1,
    localparam int CH_W   = $clog2(OUT_C)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [OUT_C*B_WIDTH-1:0]          aggr_pack,
    input  logic                              aggr_valid,
    output logic signed [Q_WIDTH-1:0]         feat_data,
    output logic [CH_W-1:0]                   feat_ch,
    output logic                              feat_last,
    output logic                              feat_valid,
    input  logic                              feat_ready,
    output logic                              buf_full,
    output logic                              drop_err,
    output logic [7:0]                        drop_cnt
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(OUT_C - 1);
    localparam int QMAX_I = (1 << (Q_WIDTH - 1)) - 1;
    localparam int QMIN_I = -(1 << (Q_WIDTH - 1));
    localparam logic signed [B_WIDTH-1:0] Q_MAX = B_WIDTH'(QMAX_I);
    localparam logic signed [B_WIDTH-1:0] Q_MIN = B_WIDTH'(QMIN_I);

    // Optional ReLU (sign bit test keeps 0x8000_0000 negative), then a
    // flooring arithmetic shift.
    function automatic logic signed [B_WIDTH-1:0] relu_shift(
        input logic signed [B_WIDTH-1:0] x
    );
        logic signed [B_WIDTH-1:0] v;
        v = x;
        if ((RELU != 0) && x[B_WIDTH-1]) begin
            v = '0;
        end
        return v >>> SHIFT;
    endfunction

    // Signed clamp into the activation range.
    function automatic logic signed [Q_WIDTH-1:0] sat_q(
        input logic signed [B_WIDTH-1:0] y
    );
        logic signed [Q_WIDTH-1:0] r;
        if (y > Q_MAX) begin
            r = Q_MAX[Q_WIDTH-1:0];
        end else if (y < Q_MIN) begin
            r = Q_MIN[Q_WIDTH-1:0];
        end else begin
            r = y[Q_WIDTH-1:0];
        end
        return r;
    endfunction

    logic [OUT_C*B_WIDTH-1:0]  mem [2];
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                cnt;
    logic [1:0]                cnt_next;
    logic [CH_W-1:0]           ch_idx;
    logic                      load;
    logic                      pop;
    logic                      push;
    logic signed [B_WIDTH-1:0] chan_p0;
    logic signed [Q_WIDTH-1:0] q_p0;

    // Handshake decisions: output reload, head pop on its last channel,
    // push accepted when a slot is free or being freed this cycle.
    always_comb begin
        load     = !feat_valid || feat_ready;
        pop      = load && (cnt != 2'd0) && (ch_idx == LAST_CH);
        push     = aggr_valid && ((cnt != 2'd2) || pop);
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + 2'd1;
            2'b01:   cnt_next = cnt - 2'd1;
            default: cnt_next = cnt;
        endcase
    end

    // ---- stage p0: select head channel and quantize ----
    always_comb begin
        chan_p0 = mem[rd_ptr][int'(ch_idx) * B_WIDTH +: B_WIDTH];
        q_p0    = sat_q(relu_shift(chan_p0));
    end

    // Pack storage; data only, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= aggr_pack;
        end
    end

    // FIFO pointers, occupancy, channel walk and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            ch_idx   <= '0;
            buf_full <= 1'b0;
            drop_err <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            cnt      <= cnt_next;
            buf_full <= (cnt_next == 2'd2);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (load && (cnt != 2'd0)) begin
                ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;
            end
            if (aggr_valid && !push) begin
                drop_err <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // ---- stage p1: output beat register, held while stalled ----
    always_ff @(posedge clk) begin
        if (rst) begin
            feat_valid <= 1'b0;
            feat_data  <= '0;
            feat_ch    <= '0;
            feat_last  <= 1'b0;
        end else if (load) begin
            if (cnt != 2'd0) begin
                feat_valid <= 1'b1;
                feat_data  <= q_p0;
                feat_ch    <= ch_idx;
                feat_last  <= (ch_idx == LAST_CH);
            end else begin
                feat_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aggr_serializer.sv
// Bench for aggr_serializer: two instances (ReLU on / off) share stimulus;
// a per-instance scoreboard of expected beats is filled as packs are sent.
module tb_aggr_serializer;

    localparam int OC = 4;
    localparam int BW = 32;
    localparam int QW = 8;

    typedef struct packed {
        logic [OC-1:0][BW-1:0] ch;
        logic [OC-1:0][QW-1:0] exp_r;
        logic [OC-1:0][QW-1:0] exp_n;
    } vec_t;

    typedef struct {
        int data;
        int ch;
        int last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [OC*BW-1:0]  aggr_pack = '0;
    logic              aggr_valid = 1'b0;
    logic              feat_ready = 1'b0;
    logic signed [QW-1:0] fd [2];
    logic [1:0]        fch [2];
    logic              flast [2];
    logic              fv [2];
    logic              bfull [2];
    logic              derr [2];
    logic [7:0]        dcnt [2];

    beat_t q [2][$];
    beat_t prev [2];
    bit    hold [2];
    vec_t  vecs [4];
    int    n_chk = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    aggr_serializer #(.OUT_C(OC), .B_WIDTH(BW), .Q_WIDTH(QW), .SHIFT(8), .RELU(1)) u_relu (
        .clk(clk), .rst(rst), .aggr_pack(aggr_pack), .aggr_valid(aggr_valid),
        .feat_data(fd[0]), .feat_ch(fch[0]), .feat_last(flast[0]), .feat_valid(fv[0]),
        .feat_ready(feat_ready), .buf_full(bfull[0]), .drop_err(derr[0]), .drop_cnt(dcnt[0])
    );

    aggr_serializer #(.OUT_C(OC), .B_WIDTH(BW), .Q_WIDTH(QW), .SHIFT(8), .RELU(0)) u_norelu (
        .clk(clk), .rst(rst), .aggr_pack(aggr_pack), .aggr_valid(aggr_valid),
        .feat_data(fd[1]), .feat_ch(fch[1]), .feat_last(flast[1]), .feat_valid(fv[1]),
        .feat_ready(feat_ready), .buf_full(bfull[1]), .drop_err(derr[1]), .drop_cnt(dcnt[1])
    );

    task automatic chk(input string name, input int d, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pack for one cycle; queue its beats when it should be kept.
    task automatic send(input int vi, input bit accept);
        logic signed [QW-1:0] s;
        beat_t b;
        aggr_pack  = vecs[vi].ch;
        aggr_valid = 1'b1;
        if (accept) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < OC; c++) begin
                    s = (d == 0) ? vecs[vi].exp_r[c] : vecs[vi].exp_n[c];
                    b.data = int'(s);
                    b.ch   = c;
                    b.last = (c == OC - 1) ? 1 : 0;
                    q[d].push_back(b);
                end
            end
        end
        tick();
        aggr_valid = 1'b0;
    endtask

    // Run until both scoreboards are empty, optionally toggling ready 1,0,0,1.
    task automatic drain(input bit bp);
        int i;
        i = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && i < 200) begin
            if (bp) feat_ready = ((i % 4) == 0) || ((i % 4) == 3);
            else    feat_ready = 1'b1;
            tick();
            i++;
        end
        feat_ready = 1'b1;
        chk("drain_left0", 0, q[0].size(), 0);
        chk("drain_left1", 1, q[1].size(), 0);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_valid"}, d, int'(fv[d]), 0);
            chk({tag, "_data"}, d, int'(fd[d]), 0);
            chk({tag, "_ch"}, d, int'(fch[d]), 0);
            chk({tag, "_last"}, d, int'(flast[d]), 0);
            chk({tag, "_full"}, d, int'(bfull[d]), 0);
            chk({tag, "_derr"}, d, int'(derr[d]), 0);
            chk({tag, "_dcnt"}, d, int'(dcnt[d]), 0);
        end
    endtask

    // Beat monitor: accepted beats against the scoreboard, stalled beats
    // against the previous cycle.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (hold[d]) begin
                    chk("stall_valid", d, int'(fv[d]), 1);
                    chk("stall_data", d, int'(fd[d]), prev[d].data);
                    chk("stall_ch", d, int'(fch[d]), prev[d].ch);
                    chk("stall_last", d, int'(flast[d]), prev[d].last);
                end
                if (fv[d] && feat_ready) begin
                    chk("beat_expected", d, int'(q[d].size() > 0), 1);
                    if (q[d].size() > 0) begin
                        e = q[d].pop_front();
                        chk("beat_data", d, int'(fd[d]), e.data);
                        chk("beat_ch", d, int'(fch[d]), e.ch);
                        chk("beat_last", d, int'(flast[d]), e.last);
                    end
                end
                hold[d]      = fv[d] && !feat_ready;
                prev[d].data = int'(fd[d]);
                prev[d].ch   = int'(fch[d]);
                prev[d].last = int'(flast[d]);
            end
        end
    end

    initial begin
        // channel order in each literal is ch3, ch2, ch1, ch0
        vecs[0].ch    = {32'h0000_3A80, 32'h7FFF_FFFF, 32'hFFFF_FF00, 32'h0000_0100};
        vecs[0].exp_r = {8'd58, 8'd127, 8'd0, 8'd1};
        vecs[0].exp_n = {8'd58, 8'd127, 8'hFF, 8'd1};
        vecs[1].ch    = {32'h0000_00FF, 32'hFFFF_8000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[1].exp_r = {8'd0, 8'd0, 8'd0, 8'd0};
        vecs[1].exp_n = {8'd0, 8'h80, 8'hFF, 8'h80};
        vecs[2].ch    = {32'h0000_8000, 32'h0000_7F00, 32'hFFFF_7F00, 32'hFFFF_FE80};
        vecs[2].exp_r = {8'd127, 8'd127, 8'd0, 8'd0};
        vecs[2].exp_n = {8'd127, 8'd127, 8'h80, 8'hFE};
        vecs[3].ch    = {32'h0000_1234, 32'h0000_007F, 32'hFFFF_FF80, 32'hFFFF_8100};
        vecs[3].exp_r = {8'd18, 8'd0, 8'd0, 8'd0};
        vecs[3].exp_n = {8'd18, 8'd0, 8'hFF, 8'h81};

        // reset state
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        feat_ready = 1'b1;
        tick();

        // table: every vector, spaced OUT_C cycles apart, ready high
        for (int vi = 0; vi < 4; vi++) begin
            send(vi, 1'b1);
            repeat (OC - 1) tick();
        end
        drain(1'b0);
        chk("table_no_drop", 0, int'(derr[0]), 0);
        chk("table_no_drop", 1, int'(derr[1]), 0);

        // latency: pack in cycle t, first beat in cycle t+2
        feat_ready = 1'b1;
        send(0, 1'b1);
        chk("lat_t1_valid", 0, int'(fv[0]), 0);
        tick();
        chk("lat_t2_valid", 0, int'(fv[0]), 1);
        chk("lat_t2_ch", 0, int'(fch[0]), 0);
        chk("lat_t2_valid", 1, int'(fv[1]), 1);
        drain(1'b0);

        // backpressure: ready toggles 1,0,0,1 while the pack streams
        send(1, 1'b1);
        drain(1'b1);

        // overflow: three packs back-to-back with ready low
        feat_ready = 1'b0;
        send(2, 1'b1);
        send(3, 1'b1);
        chk("ovf_full", 0, int'(bfull[0]), 1);
        send(0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk("ovf_full_after", d, int'(bfull[d]), 1);
            chk("ovf_derr", d, int'(derr[d]), 1);
            chk("ovf_dcnt", d, int'(dcnt[d]), 1);
        end
        drain(1'b0);
        chk("ovf_full_end", 0, int'(bfull[0]), 0);

        // push in the cycle the head's last channel loads, with cnt == 2
        feat_ready = 1'b0;
        send(0, 1'b1);
        send(1, 1'b1);
        feat_ready = 1'b1;
        tick();
        tick();
        send(2, 1'b1);
        for (int d = 0; d < 2; d++) begin
            chk("pap_dcnt", d, int'(dcnt[d]), 1);
            chk("pap_full", d, int'(bfull[d]), 1);
            chk("pap_ch3", d, int'(fch[d]), 3);
        end
        drain(1'b0);

        // reset mid-stream after ch1, with a pack offered in the reset cycle
        feat_ready = 1'b1;
        send(3, 1'b1);
        tick();
        tick();
        chk("mid_ch1", 0, int'(fch[0]), 1);
        rst        = 1'b1;
        aggr_pack  = vecs[1].ch;
        aggr_valid = 1'b1;
        q[0].delete();
        q[1].delete();
        tick();
        aggr_valid = 1'b0;
        rst        = 1'b0;
        chk_reset_outputs("midrst");
        tick();
        chk("midrst_idle", 0, int'(fv[0]), 0);
        send(0, 1'b1);
        drain(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
